ahb_lite_sram_slave: RTL and testbench
======================================

Name: ahb_lite_sram_slave

Overview:
Parametrised AHB-lite slave with an internal byte-addressable SRAM. It is the next-generation DUT for the AHB slave verification environment. It generalises data width, memory depth and wait-state count, and adds byte-lane writes, sub-word reads and a two-cycle ERROR response for illegal transfers. It sits behind an AHB-lite decoder and drives hreadyout/hresp/hrdata back to the master mux.

Parameters:
ADDR_WIDTH, 32, haddr width
DATA_WIDTH, 32, hwdata/hrdata width; legal values 32 or 64
MEM_DEPTH, 1024, number of DATA_WIDTH-bit words
WAIT_STATES, 0, hreadyout-low cycles inserted per OKAY data phase; legal range 0..15

Ports:
hclk  input  1  clock, all logic on rising edge
hreset  input  1  synchronous, active-high reset
hsel  input  1  slave select
haddr  input  ADDR_WIDTH  byte address
htrans  input  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
hwrite  input  1  1=write
hsize  input  3  transfer size, 2**hsize bytes
hburst  input  3  burst type; carried, not decoded
hprot  input  4  protection; ignored
hready  input  1  bus-level ready (from mux)
hwdata  input  DATA_WIDTH  write data, data phase
hreadyout  output  1  slave ready
hresp  output  1  0=OKAY, 1=ERROR
hrdata  output  DATA_WIDTH  read data

Behaviour:
- Reset (hreset=1 at an edge): FSM to IDLE; hreadyout=1, hresp=0, hrdata=0; pending data phase dropped with no memory write; memory contents preserved.
- Address phase accepted when hsel & hready & htrans[1]. Captured into registers: addr, hwrite, hsize.
- IDLE/BUSY or hsel=0 with hready=1: no transfer. Next cycle gives a zero-wait OKAY (hreadyout=1, hresp=0).
- Illegal transfer: any one of the following.
  - haddr >= MEM_DEPTH*DATA_WIDTH/8.
  - 2**hsize > DATA_WIDTH/8.
  - haddr not aligned to 2**hsize.
- FSM states:
  - IDLE: hreadyout=1, hresp=0. On accept: illegal -> ERR1; WAIT_STATES>0 -> WAIT (counter loaded with WAIT_STATES-1); otherwise -> LAST.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 -> LAST.
  - LAST: hreadyout=1, hresp=0. Transfer completes on this cycle. A new accept here follows the IDLE rules (pipelined back-to-back); with no accept -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. A new accept follows the IDLE rules.
- Write: memory is updated at the LAST-cycle edge using hwdata and byte enables.
  - Byte enables: 2**size_q contiguous lanes starting at addr_q[log2(DATA_WIDTH/8)-1:0].
  - Unselected lanes are unchanged. No write occurs on ERROR.
- Read: in LAST, hrdata = mem[addr_q word index], full word with all lanes driven. In every other state hrdata=0.
- Read-after-write to the same address on consecutive transfers returns the new data, because the write commits before the read's data phase. No forwarding is needed.
- Every transfer is independent; the slave computes no burst addresses. A WRAP/INCR burst behaves as its sequence of single transfers.
- WAIT_STATES=0: OKAY transfers take 1 data cycle; ERROR always takes 2.

Decomposition:
- Package ahb_pkg:
  - htrans_t, hsize_t, hburst_t enums.
  - HRESP_OKAY/HRESP_ERROR constants.
  - fsm state_t (IDLE, WAIT, LAST, ERR1, ERR2).
  - function byte_en(addr_lsb, size) returning a DATA_WIDTH/8 strobe.
- Sub-module ahb_sram_mem: synchronous byte-enable write, combinational read, parameters DATA_WIDTH and MEM_DEPTH.

Test Plan:
- Reset, then idle bus -> hreadyout=1, hresp=0, hrdata=0 each cycle.
- WAIT_STATES=0, write 32'hDEADBEEF to 0x10 then read 0x10 back-to-back -> read data phase hrdata=32'hDEADBEEF, hreadyout never low.
- WAIT_STATES=2, single read of 0x20 -> hreadyout low for exactly 2 cycles, then high with data.
- Byte write 8'hAA (hsize=0) to 0x11 over word 32'h00000000 -> readback 32'h0000AA00.
- Halfword access to 0x13 (misaligned), then read of address 0x1000 with MEM_DEPTH=1024 -> for each: cycle1 hreadyout=0/hresp=1, cycle2 hreadyout=1/hresp=1; memory unchanged.
- Assert hreset during a WAIT-state write -> next cycle hreadyout=1, hresp=0; target word retains its old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite types, response codes, slave FSM states and lane-strobe helper.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4W    = 3'd4,
        HSIZE_8W    = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_LAST = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    // Widest supported bus is 64 bits, so strobes are 8 lanes; callers truncate.
    localparam int unsigned MAX_STRB = 8;

    // 2**size contiguous lanes starting at addr_lsb. Only meaningful for legal
    // (aligned, in-width) transfers, where the shifted mask never overflows.
    function automatic logic [MAX_STRB-1:0] byte_en(input logic [2:0] addr_lsb,
                                                    input logic [2:0] size);
        logic [MAX_STRB-1:0] w_base;
        case (size)
            3'd0:    w_base = 8'h01;
            3'd1:    w_base = 8'h03;
            3'd2:    w_base = 8'h0F;
            default: w_base = 8'hFF;
        endcase
        return w_base << addr_lsb;
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// Word-organised SRAM with per-byte write enables and combinational read.
module ahb_sram_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_we,
    input  logic [DATA_WIDTH/8-1:0]       i_be,
    input  logic [$clog2(MEM_DEPTH)-1:0]  i_addr,
    input  logic [DATA_WIDTH-1:0]         i_wdata,
    output logic [DATA_WIDTH-1:0]         o_rdata
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Byte-lane write; unselected lanes keep their contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int unsigned b = 0; b < NBYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-lite slave fronting a byte-addressable SRAM, with programmable wait
// states, sub-word accesses and a two-cycle ERROR response for illegal transfers.
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic                  hready,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned BW     = $clog2(NBYTES);
    localparam int unsigned AW     = $clog2(MEM_DEPTH);
    localparam int unsigned LW     = BW + AW;
    localparam logic [ADDR_WIDTH:0] LP_MEM_BYTES = (ADDR_WIDTH+1)'(MEM_DEPTH * NBYTES);

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic [LW-1:0]       r_addr;
    logic                r_write;
    logic [2:0]          r_size;
    logic                r_hreadyout;
    logic                r_hresp;

    logic                w_accept;
    logic                w_out_of_range;
    logic                w_too_wide;
    logic                w_misalign;
    logic                w_illegal;
    logic [2:0]          w_size_mask;
    logic [NBYTES-1:0]   w_be;
    logic                w_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                w_unused;

    // Burst type, protection and the SEQ/NONSEQ distinction are not needed:
    // every transfer is decoded independently from its own address.
    assign w_unused = ^{hburst, hprot, htrans[0]};

    assign w_accept = hsel & hready & htrans[1];

    // Address LSBs that must be zero for the requested size.
    always_comb begin
        w_size_mask = 3'b000;
        case (hsize[1:0])
            2'd0: w_size_mask = 3'b000;
            2'd1: w_size_mask = 3'b001;
            2'd2: w_size_mask = 3'b011;
            2'd3: w_size_mask = 3'b111;
            default: w_size_mask = 3'b000;
        endcase
    end

    assign w_out_of_range = ({1'b0, haddr} >= LP_MEM_BYTES);
    assign w_too_wide     = (hsize > 3'(BW));
    assign w_misalign     = |(haddr[2:0] & w_size_mask);
    assign w_illegal      = w_out_of_range | w_too_wide | w_misalign;

    // Transfer FSM: address-phase capture, wait-state count and response sequencing.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
        end else begin
            case (r_state)
                S_IDLE, S_LAST, S_ERR2: begin
                    if (w_accept) begin
                        r_addr  <= haddr[LW-1:0];
                        r_write <= hwrite;
                        r_size  <= hsize;
                        if (w_illegal) begin
                            r_state     <= S_ERR1;
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            r_state     <= S_WAIT;
                            r_cnt       <= 4'(WAIT_STATES - 1);
                            r_hreadyout <= 1'b0;
                            r_hresp     <= HRESP_OKAY;
                        end else begin
                            r_state     <= S_LAST;
                            r_hreadyout <= 1'b1;
                            r_hresp     <= HRESP_OKAY;
                        end
                    end else begin
                        r_state     <= S_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_LAST;
                        r_hreadyout <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    r_state     <= S_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign w_be = NBYTES'(byte_en(3'(r_addr[BW-1:0]), r_size));
    // A reset landing on the LAST edge drops the pending write.
    assign w_we = (r_state == S_LAST) && r_write && !hreset;

    ahb_sram_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .i_clk   (hclk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (r_addr[LW-1:BW]),
        .i_wdata (hwdata),
        .o_rdata (w_rdata)
    );

    assign hreadyout = r_hreadyout;
    assign hresp     = r_hresp;
    // Combinational read so a write committed on the previous edge is visible.
    assign hrdata    = ((r_state == S_LAST) && !r_write) ? w_rdata : '0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench: one zero-wait and one two-wait slave sharing the address bus,
// each selected by its own hsel and fed its own hreadyout as hready.
module tb_ahb_lite_sram_slave;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel2;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        ready0, ready2;
    logic        resp0, resp2;
    logic [31:0] rdata0, rdata2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(ready0),
        .hwdata(hwdata), .hreadyout(ready0), .hresp(resp0), .hrdata(rdata0)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .WAIT_STATES(2)) u_dut2 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready(ready2),
        .hwdata(hwdata), .hreadyout(ready2), .hresp(resp2), .hrdata(rdata2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? ready0 : ready2;
    endfunction

    function automatic logic rsp(input int s);
        return (s == 0) ? resp0 : resp2;
    endfunction

    function automatic logic [31:0] rdd(input int s);
        return (s == 0) ? rdata0 : rdata2;
    endfunction

    task automatic bus_idle();
        hsel0 = 1'b0; hsel2 = 1'b0; htrans = 2'd0; hwrite = 1'b0;
        haddr = '0; hsize = 3'd2;
    endtask

    // Single non-pipelined transfer; reports the first data-phase cycle, the
    // number of hreadyout-low cycles and the completing cycle's response/data.
    task automatic xfer(input int sel, input logic wr, input logic [31:0] addr,
                        input logic [2:0] size, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic first_rdy,
                        output logic first_resp, output logic last_resp, output int waits);
        if (sel == 0) hsel0 = 1'b1; else hsel2 = 1'b1;
        htrans = 2'd2; hwrite = wr; haddr = addr; hsize = size;
        tick();
        bus_idle();
        hwdata     = wdata;
        first_rdy  = rdy(sel);
        first_resp = rsp(sel);
        waits = 0;
        while (!rdy(sel) && waits < 20) begin
            waits++;
            tick();
        end
        if (waits >= 20) check("xfer_timeout", 32'(waits), 32'd0);
        rd        = rdd(sel);
        last_resp = rsp(sel);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        fr, fs, ls;
        int          w;

        bus_idle();
        hburst = 3'd0; hprot = 4'b0011; hwdata = '0;
        hreset = 1'b1;
        tick(); tick();
        check("rst_rdy0",  32'(ready0), 32'd1);
        check("rst_resp0", 32'(resp0),  32'd0);
        check("rst_rdat0", rdata0,      32'd0);
        check("rst_rdy2",  32'(ready2), 32'd1);
        hreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_rdy",  32'(ready0), 32'd1);
            check("idle_resp", 32'(resp0),  32'd0);
            check("idle_rdat", rdata0,      32'd0);
        end
        // BUSY while selected is not a transfer
        hsel0 = 1'b1; htrans = 2'd1; haddr = 32'h13; hsize = 3'd1;
        tick();
        bus_idle();
        check("busy_rdy",  32'(ready0), 32'd1);
        check("busy_resp", 32'(resp0),  32'd0);

        // Byte and halfword lane writes
        xfer(0, 1'b1, 32'h10, 3'd2, 32'h0000_0000, rd, fr, fs, ls, w);
        check("w0_waits", 32'(w), 32'd0);
        check("w0_resp", 32'(ls), 32'd0);
        xfer(0, 1'b1, 32'h11, 3'd0, 32'h5555_AA55, rd, fr, fs, ls, w);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("byte_rd", rd, 32'h0000_AA00);
        xfer(0, 1'b1, 32'h12, 3'd1, 32'h1234_9999, rd, fr, fs, ls, w);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("half_rd", rd, 32'h1234_AA00);

        // Pipelined write then read of 0x10
        hsel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h10; hsize = 3'd2;
        tick();
        hwdata = 32'hDEAD_BEEF; hwrite = 1'b0;
        check("b2b_w_rdy", 32'(ready0), 32'd1);
        tick();
        bus_idle();
        check("b2b_r_rdy",  32'(ready0), 32'd1);
        check("b2b_r_resp", 32'(resp0),  32'd0);
        check("b2b_r_data", rdata0,      32'hDEAD_BEEF);
        tick();
        check("b2b_idle_rdat", rdata0, 32'd0);

        // Illegal: misaligned halfword write, must not touch memory
        xfer(0, 1'b1, 32'h13, 3'd1, 32'hFFFF_FFFF, rd, fr, fs, ls, w);
        check("mis_c1_rdy",  32'(fr), 32'd0);
        check("mis_c1_resp", 32'(fs), 32'd1);
        check("mis_c2_resp", 32'(ls), 32'd1);
        check("mis_waits",   32'(w),  32'd1);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("mis_unchanged", rd, 32'hDEAD_BEEF);

        // Illegal: first address past the end
        xfer(0, 1'b0, 32'h1000, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("oor_c1_rdy",  32'(fr), 32'd0);
        check("oor_c1_resp", 32'(fs), 32'd1);
        check("oor_c2_resp", 32'(ls), 32'd1);
        check("oor_waits",   32'(w),  32'd1);
        check("oor_rdat",    rd,      32'd0);

        // Illegal: 8-byte transfer on a 4-byte bus
        xfer(0, 1'b1, 32'h10, 3'd3, 32'h0, rd, fr, fs, ls, w);
        check("wide_c1_resp", 32'(fs), 32'd1);
        xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("wide_unchanged", rd, 32'hDEAD_BEEF);

        // Last legal word
        xfer(0, 1'b1, 32'hFFC, 3'd2, 32'hA5A5_5A5A, rd, fr, fs, ls, w);
        check("top_w_resp", 32'(ls), 32'd0);
        xfer(0, 1'b0, 32'hFFC, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("top_rd", rd, 32'hA5A5_5A5A);

        // Two wait states
        xfer(1, 1'b1, 32'h20, 3'd2, 32'h0BAD_F00D, rd, fr, fs, ls, w);
        check("ws2_w_waits", 32'(w), 32'd2);
        xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("ws2_r_first", 32'(fr), 32'd0);
        check("ws2_r_waits", 32'(w),  32'd2);
        check("ws2_r_resp",  32'(ls), 32'd0);
        check("ws2_r_data",  rd,      32'h0BAD_F00D);

        // Reset during a wait-state write drops the write
        xfer(1, 1'b1, 32'h30, 3'd2, 32'h1122_3344, rd, fr, fs, ls, w);
        hsel2 = 1'b1; htrans = 2'd2; hwrite = 1'b1; haddr = 32'h30; hsize = 3'd2;
        tick();
        bus_idle();
        hwdata = 32'hCAFE_F00D;
        check("rstw_in_wait", 32'(ready2), 32'd0);
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        check("rstw_rdy",  32'(ready2), 32'd1);
        check("rstw_resp", 32'(resp2),  32'd0);
        xfer(1, 1'b0, 32'h30, 3'd2, 32'h0, rd, fr, fs, ls, w);
        check("rstw_kept", rd, 32'h1122_3344);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
